// File: rtl/wimax_cc_pkg.sv
// Shared constants for the tail-biting K=7 convolutional encoder: generator taps,
// FSM encoding, puncture masks and the tap/puncture helper functions.
package wimax_cc_pkg;

   localparam int K = 7;
   localparam logic [6:0] G1 = 7'o171;
   localparam logic [6:0] G2 = 7'o133;

   typedef enum logic [1:0] {
      ST_FILL   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ENCODE = 2'd2
   } cc_state_e;

   localparam logic [1:0] RATE_2_3 = 2'd1;
   localparam logic [1:0] RATE_3_4 = 2'd2;

   // Keep masks: bit p is pattern position p, 1 means the bit is emitted.
   localparam logic [2:0] P23_X   = 3'b001;
   localparam logic [2:0] P23_Y   = 3'b011;
   localparam logic [2:0] P34_X   = 3'b101;
   localparam logic [2:0] P34_Y   = 3'b011;
   localparam logic [1:0] P23_LEN = 2'd2;
   localparam logic [1:0] P34_LEN = 2'd3;

   function automatic logic cc_tap(input logic u, input logic [5:0] s, input logic [6:0] g);
      logic [6:0] reg_v;
      reg_v = {u, s[0], s[1], s[2], s[3], s[4], s[5]};
      return ^(reg_v & g);
   endfunction

   function automatic logic [1:0] punc_len(input logic [1:0] rate);
      logic [1:0] len_v;
      case (rate)
         RATE_2_3: len_v = P23_LEN;
         RATE_3_4: len_v = P34_LEN;
         default:  len_v = 2'd1;
      endcase
      return len_v;
   endfunction

   function automatic logic punc_keep(input logic [1:0] rate, input logic [1:0] pos, input logic phase);
      logic [2:0] mask_v;
      case (rate)
         RATE_2_3: mask_v = phase ? P23_Y : P23_X;
         RATE_3_4: mask_v = phase ? P34_Y : P34_X;
         default:  mask_v = 3'b111;
      endcase
      return mask_v[pos];
   endfunction

endpackage

// File: rtl/cc_blk_buf.sv
// Single-bit-wide block buffer for cc_tb_encoder: synchronous write, registered read.
module cc_blk_buf
   import wimax_cc_pkg::*;
#(
   parameter int DEPTH = 576,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_data
);

   logic mem_r [0:DEPTH-1];

   // Storage array, written one accepted bit at a time.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Registered read port; data appears the cycle after rd_en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= 1'b0;
      end else if (rd_en) begin
         rd_data <= mem_r[rd_addr];
      end
   end

endmodule

// File: rtl/cc_tb_encoder.sv
// Tail-biting K=7 convolutional encoder (G1=171, G2=133 octal) with a whole-block buffer.
// Defining CC_PUNCTURE_EN adds the rate[1:0] port and 2/3, 3/4 puncturing.
module cc_tb_encoder
   import wimax_cc_pkg::*;
#(
   parameter int BLK_MAX = 576,
   parameter int CNT_W   = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_bits,
   input  logic       in_valid,
   input  logic       in_last,
`ifdef CC_PUNCTURE_EN
   input  logic [1:0] rate,
`endif
   output logic       in_ready,
   output logic       out_bits,
   output logic       out_valid,
   output logic       out_last,
   output logic       blk_err
);

   cc_state_e        state_r;
   cc_state_e        state_s;
   logic [CNT_W-1:0] wr_cnt_r;
   logic [CNT_W-1:0] blk_len_r;
   logic [CNT_W-1:0] bit_idx_r;
   logic [CNT_W-1:0] wr_next_s;
   logic [CNT_W-1:0] rd_addr_s;
   logic [5:0]       tail_r;
   logic [5:0]       enc_s_r;
   logic             phase_r;
   logic [1:0]       pos_r;
   logic [1:0]       rate_r;
   logic [1:0]       rate_in_s;
   logic             accept_s;
   logic             short_s;
   logic             blk_end_s;
   logic             last_bit_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic             u_s;
   logic             x_s;
   logic             y_s;
   logic             keep_s;
   logic             y_keep_s;
   logic             out_bits_s;
   logic             out_valid_s;
   logic             out_last_s;
   logic             blk_err_s;
   logic             in_ready_s;
   logic             in_ready_r;
   logic             out_bits_r;
   logic             out_valid_r;
   logic             out_last_r;
   logic             blk_err_r;

`ifdef CC_PUNCTURE_EN
   assign rate_in_s = rate;
`else
   assign rate_in_s = 2'd0;
`endif

   cc_blk_buf #(
      .DEPTH (BLK_MAX),
      .AW    (CNT_W)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en_s),
      .wr_addr (wr_cnt_r),
      .wr_data (in_bits),
      .rd_en   (rd_en_s),
      .rd_addr (rd_addr_s),
      .rd_data (u_s)
   );

   // Handshake, block-boundary and buffer address decode.
   always_comb begin
      accept_s   = in_valid && in_ready_r && (state_r == ST_FILL);
      wr_next_s  = wr_cnt_r + CNT_W'(1);
      short_s    = in_last && (wr_next_s < CNT_W'(K));
      blk_end_s  = accept_s && (in_last || (wr_next_s == CNT_W'(BLK_MAX)));
      last_bit_s = (bit_idx_r == (blk_len_r - CNT_W'(1)));
      wr_en_s    = accept_s;
      // Fetch bit i+1 during the Y phase of bit i so it is ready for the next X phase.
      rd_en_s    = (state_r == ST_LOAD) || ((state_r == ST_ENCODE) && phase_r && !last_bit_s);
      if (state_r == ST_LOAD) begin
         rd_addr_s = {CNT_W{1'b0}};
      end else begin
         rd_addr_s = bit_idx_r + CNT_W'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_FILL;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic; short blocks are dropped and stay in FILL.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_FILL: begin
            if (blk_end_s && !short_s) begin
               state_s = ST_LOAD;
            end else begin
               state_s = ST_FILL;
            end
         end
         ST_LOAD: begin
            state_s = ST_ENCODE;
         end
         ST_ENCODE: begin
            if (phase_r && last_bit_s) begin
               state_s = ST_FILL;
            end else begin
               state_s = ST_ENCODE;
            end
         end
         default: begin
            state_s = ST_FILL;
         end
      endcase
   end

   // Counters, tail shadow and encoder shift register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_cnt_r  <= {CNT_W{1'b0}};
         blk_len_r <= {CNT_W{1'b0}};
         bit_idx_r <= {CNT_W{1'b0}};
         tail_r    <= 6'd0;
         enc_s_r   <= 6'd0;
         phase_r   <= 1'b0;
         pos_r     <= 2'd0;
         rate_r    <= 2'd0;
      end else begin
         case (state_r)
            ST_FILL: begin
               if (accept_s) begin
                  tail_r <= {tail_r[4:0], in_bits};
                  if (blk_end_s) begin
                     wr_cnt_r <= {CNT_W{1'b0}};
                     if (!short_s) begin
                        blk_len_r <= wr_next_s;
                     end
                  end else begin
                     wr_cnt_r <= wr_next_s;
                  end
               end
            end
            ST_LOAD: begin
               enc_s_r   <= tail_r;
               bit_idx_r <= {CNT_W{1'b0}};
               phase_r   <= 1'b0;
               pos_r     <= 2'd0;
               rate_r    <= rate_in_s;
            end
            ST_ENCODE: begin
               phase_r <= ~phase_r;
               if (phase_r) begin
                  enc_s_r   <= {enc_s_r[4:0], u_s};
                  bit_idx_r <= bit_idx_r + CNT_W'(1);
                  if ((pos_r + 2'd1) >= punc_len(rate_r)) begin
                     pos_r <= 2'd0;
                  end else begin
                     pos_r <= pos_r + 2'd1;
                  end
               end
            end
            default: begin
               phase_r <= 1'b0;
            end
         endcase
      end
   end

   // FSM output logic: coded bit selection, puncturing and block status.
   always_comb begin
      x_s         = cc_tap(u_s, enc_s_r, G1);
      y_s         = cc_tap(u_s, enc_s_r, G2);
      keep_s      = punc_keep(rate_r, pos_r, phase_r);
      y_keep_s    = punc_keep(rate_r, pos_r, 1'b1);
      out_valid_s = (state_r == ST_ENCODE) && keep_s;
      out_bits_s  = out_valid_s && (phase_r ? y_s : x_s);
      // When Y of the final bit is punctured, its X is the last emitted bit.
      out_last_s  = out_valid_s && last_bit_s && (phase_r || !y_keep_s);
      blk_err_s   = blk_end_s && (short_s || !in_last);
      in_ready_s  = (state_s == ST_FILL);
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in_ready_r  <= 1'b1;
         out_bits_r  <= 1'b0;
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         blk_err_r   <= 1'b0;
      end else begin
         in_ready_r  <= in_ready_s;
         out_bits_r  <= out_bits_s;
         out_valid_r <= out_valid_s;
         out_last_r  <= out_last_s;
         blk_err_r   <= blk_err_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_bits  = out_bits_r;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign blk_err   = blk_err_r;

endmodule

// File: tb/tb_cc_tb_encoder.sv
// Self-checking bench for cc_tb_encoder: circular-convolution reference model,
// per-cycle output compare, randomized and directed blocks (CC_PUNCTURE_EN aware).
module tb_cc_tb_encoder;

   logic clk;
   logic reset;
   logic in_bits;
   logic in_valid;
   logic in_last;
   logic in_ready;
   logic out_bits;
   logic out_valid;
   logic out_last;
   logic blk_err;
`ifdef CC_PUNCTURE_EN
   logic [1:0] rate;
`endif

   int         checks;
   int         errors;
   int         cyc;
   int         hs_cyc;
   int         err_seen;
   int         exp_err;
   logic       exp_short;
   logic       first_pending;
   logic       drv_final;
   logic [5:0] exp_preload;
   bit         blk_bits[$];
   logic [1:0] model_q[$];
   logic [1:0] exp_q[$];

   cc_tb_encoder #(
      .BLK_MAX (576),
      .CNT_W   (10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_bits   (in_bits),
      .in_valid  (in_valid),
      .in_last   (in_last),
`ifdef CC_PUNCTURE_EN
      .rate      (rate),
`endif
      .in_ready  (in_ready),
      .out_bits  (out_bits),
      .out_valid (out_valid),
      .out_last  (out_last),
      .blk_err   (blk_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Coded stream as circular convolution of the block with the generator taps.
   task automatic model_block(input int rate_i);
      int         n;
      int         p;
      logic [6:0] g1;
      logic [6:0] g2;
      logic       x;
      logic       y;
      logic       u;
      logic       xk;
      logic       yk;
      logic [1:0] tmp;
      g1 = 7'o171;
      g2 = 7'o133;
      n  = blk_bits.size();
      model_q.delete();
      for (int i = 0; i < n; i++) begin
         x = 1'b0;
         y = 1'b0;
         for (int d = 0; d < 7; d++) begin
            u = blk_bits[(i - d + n) % n];
            if (g1[6-d]) x = x ^ u;
            if (g2[6-d]) y = y ^ u;
         end
         p  = (rate_i == 1) ? (i % 2) : (rate_i == 2) ? (i % 3) : 0;
         xk = (rate_i == 1) ? (p == 0) : (rate_i == 2) ? (p != 1) : 1'b1;
         yk = (rate_i == 2) ? (p != 2) : 1'b1;
         if (xk) model_q.push_back({x, 1'b0});
         if (yk) model_q.push_back({y, 1'b0});
      end
      if (model_q.size() > 0) begin
         tmp = model_q.pop_back();
         model_q.push_back({tmp[1], 1'b1});
      end
   endtask

   task automatic load_pattern(input logic [63:0] v, input int n);
      blk_bits.delete();
      for (int i = 0; i < n; i++) blk_bits.push_back(v[n-1-i]);
   endtask

   task automatic load_random(input int n);
      blk_bits.delete();
      for (int i = 0; i < n; i++) blk_bits.push_back(1'($urandom));
   endtask

   task automatic monitor_loop();
      logic [1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            first_pending = 1'b0;
         end else begin
            if (in_valid && in_ready && drv_final) begin
               hs_cyc        = cyc;
               first_pending = 1'b1;
            end
            if (blk_err) err_seen++;
            if (out_valid) begin
               if (first_pending) begin
                  check("latency", 32'(cyc - hs_cyc), 32'd3);
                  first_pending = 1'b0;
               end
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_valid actual bit=%0b last=%0b required none", out_bits, out_last);
               end else begin
                  e = exp_q.pop_front();
                  check("coded_bit_last", 32'({out_bits, out_last}), 32'(e));
               end
            end
         end
      end
   endtask

   task automatic start_block(input logic with_last, input int rate_i);
      int n;
      int t;
      n = blk_bits.size();
      exp_short = with_last && (n < 7);
      exp_err   = (exp_short || !with_last) ? 1 : 0;
      if (!exp_short) begin
         model_block(rate_i);
         foreach (model_q[i]) exp_q.push_back(model_q[i]);
         for (int k = 0; k < 6; k++) exp_preload[k] = blk_bits[n-1-k];
      end
      err_seen = 0;
`ifdef CC_PUNCTURE_EN
      rate = 2'(rate_i);
`endif
      @(posedge clk);
      #1;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            in_bits  = 1'($urandom);
            @(posedge clk);
            #1;
         end
         in_valid  = 1'b1;
         in_bits   = blk_bits[i];
         in_last   = with_last && (i == n - 1);
         drv_final = (i == n - 1);
         t = 0;
         while (t < 3000) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
         end
         if (t >= 3000) begin
            check("in_ready_timeout", 32'd0, 32'd1);
            in_valid  = 1'b0;
            drv_final = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         in_valid  = 1'b0;
         in_last   = 1'b0;
         drv_final = 1'b0;
      end
   endtask

   task automatic finish_block();
      int t;
      t = 0;
      while (t < 4000 && exp_q.size() != 0) begin
         @(negedge clk);
         t++;
      end
      repeat (6) @(negedge clk);
      check("drain_remaining", 32'(exp_q.size()), 32'd0);
      check("blk_err_pulses", 32'(err_seen), 32'(exp_err));
      check("in_ready_idle", 32'(in_ready), 32'd1);
      if (!exp_short) check("tailbite_state", 32'(dut.enc_s_r), 32'(exp_preload));
      exp_q.delete();
   endtask

   task automatic run_block(input logic with_last, input int rate_i);
      start_block(with_last, rate_i);
      finish_block();
   endtask

   initial begin
      logic [31:0] acc;
      int          t;
      checks = 0; errors = 0; cyc = 0; hs_cyc = 0; err_seen = 0; exp_err = 0;
      exp_short = 1'b0; first_pending = 1'b0; drv_final = 1'b0; exp_preload = 6'd0;
      in_bits = 1'b0; in_valid = 1'b0; in_last = 1'b0; reset = 1'b0;
`ifdef CC_PUNCTURE_EN
      rate = 2'd0;
`endif
      fork
         monitor_loop();
      join_none

      // Hand-computed pins on the reference model.
      load_pattern(64'h80, 8);
      model_block(0);
      acc = 32'd0;
      foreach (model_q[i]) acc = (acc << 1) | 32'(model_q[i][1]);
      check("model_impulse", acc, 32'b1110111100011100);
      check("model_impulse_last", 32'(model_q[15][0]), 32'd1);
      load_pattern(64'h01, 8);
      model_block(0);
      acc = 32'd0;
      foreach (model_q[i]) acc = (acc << 1) | 32'(model_q[i][1]);
      check("model_wrap", acc, 32'b1011110001110011);
      load_pattern(64'd0, 48);
      model_block(0);
      acc = 32'd0;
      foreach (model_q[i]) acc = acc | 32'(model_q[i][1]);
      check("model_zero_len", 32'(model_q.size()), 32'd96);
      check("model_zero_bits", acc, 32'd0);
      load_random(12);
      model_block(2);
      check("model_r34_len", 32'(model_q.size()), 32'd16);
      model_block(1);
      check("model_r23_len", 32'(model_q.size()), 32'd18);

      // Reset state.
      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_bits", 32'(out_bits), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_blk_err", 32'(blk_err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;

      load_pattern(64'd0, 48);
      run_block(1'b1, 0);
      load_pattern(64'h80, 8);
      run_block(1'b1, 0);
      load_pattern(64'h01, 8);
      run_block(1'b1, 0);
      load_random(6);
      run_block(1'b1, 0);
      load_random(8);
      run_block(1'b1, 0);
      load_random(7);
      run_block(1'b1, 0);

      for (int b = 0; b < 6; b++) begin
         load_random($urandom_range(7, 60));
         run_block(1'b1, 0);
      end

      // Reset in the middle of encoding a 48-bit block.
      load_random(48);
      start_block(1'b1, 0);
      t = 0;
      while (t < 2000 && exp_q.size() > 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      check("mid_encode_valid", 32'(out_valid), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      load_random(48);
      run_block(1'b1, 0);

      // Overlong block: 576 bits without in_last.
      load_random(576);
      run_block(1'b0, 0);

`ifdef CC_PUNCTURE_EN
      load_random(12);
      run_block(1'b1, 2);
      run_block(1'b1, 1);
      run_block(1'b1, 3);
      load_random(13);
      run_block(1'b1, 2);
      load_random(11);
      run_block(1'b1, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
